// File: rtl/tt_adder_arbiter.sv
// tt_adder_arbiter: round-robin front end for one shared W-bit adder.
// Requesters hand over operand pairs on a valid/ready handshake; one op is
// in flight at a time (IDLE -> EXEC -> RESP), and the registered result
// leaves on a single response channel with backpressure.
module tt_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [W-1:0]        resp_sum,
    output logic                resp_carry,
    output logic [IDW-1:0]      resp_id,
    output logic                busy,
    output logic [15:0]         op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [IDW-1:0] id_q, id_d;
    logic           rv_q, rv_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [W-1:0]   gnt_a, gnt_b;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        int c;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid[c]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(c);
                gnt_a     = req_a[c*W +: W];
                gnt_b     = req_b[c*W +: W];
            end
        end
    end

    // Next-state, datapath and handshake decode; ready is masked by rst so
    // nothing is offered while the block is being reset.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        rv_d      = rv_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        rid_d     = rid_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (gnt_found && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
                rid_d   = id_q;
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    rv_d    = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            rv_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            rid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            rid_q   <= rid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign resp_valid = rv_q;
    assign resp_sum   = sum_q;
    assign resp_carry = carry_q;
    assign resp_id    = rid_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_tt_adder_arbiter.sv
// Bench for tt_adder_arbiter: expected responses are queued at grant time
// and compared by a monitor when the response handshake happens.
module tb_tt_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid, resp_ready;
    logic [W-1:0]        resp_sum;
    logic                resp_carry;
    logic [IDW-1:0]      resp_id;
    logic                busy;
    logic [15:0]         op_count;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic           carry;
    } exp_t;

    exp_t        q[$];
    logic [15:0] exp_cnt;
    int          n_chk  = 0;
    int          n_pass = 0;

    tt_adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_id(resp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    endtask

    // Response monitor: handshake seen between edges completes at the next edge.
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_sum", 32'(resp_sum), 32'(e.sum));
                chk("resp_carry", 32'(resp_carry), 32'(e.carry));
                chk("op_count_pre", 32'(op_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    // Wait for a grant, check it is requester r, queue its expected result,
    // then drive the next valid mask and check the EXEC cycle.
    task automatic expect_grant(input int r, input logic [NREQ-1:0] nxt);
        exp_t       e;
        logic [8:0] s;
        int         n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(req_ready), 32'(1) << r);
        s       = {1'b0, op_a[r]} + {1'b0, op_b[r]};
        e.id    = IDW'(r);
        e.sum   = s[W-1:0];
        e.carry = s[W];
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = nxt;
        @(negedge clk);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic reset_now();
        rst       = 1'b1;
        req_valid = 4'b0001;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", 32'({resp_valid, resp_sum, resp_carry, resp_id}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        exp_cnt   = '0;
    endtask

    task automatic single(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        op_a[r]   = a;
        op_b[r]   = b;
        req_valid = NREQ'(1) << r;
        expect_grant(r, '0);
        drain();
    endtask

    task automatic no_resp(input int cycles, input logic [15:0] cnt);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (resp_valid || op_count != cnt || i == cycles - 1) begin
                chk("abort_valid", 32'(resp_valid), 32'd0);
                chk("abort_count", 32'(op_count), 32'(cnt));
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt0;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        exp_cnt    = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        reset_now();

        // single op
        single(1, 8'h12, 8'h34);
        @(negedge clk);
        chk("single_count", 32'(op_count), 32'd1);

        // carry cases
        single(0, 8'hFF, 8'h01);
        single(0, 8'h80, 8'h80);
        single(0, 8'h7F, 8'h01);
        @(negedge clk);
        chk("carry_count", 32'(op_count), 32'd4);

        // fairness from reset
        reset_now();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 8'(8'h10 * (i + 1));
            op_b[i] = 8'(8'h03 + i);
        end
        req_valid = 4'b1111;
        expect_grant(0, 4'b1111);
        expect_grant(1, 4'b1111);
        expect_grant(2, 4'b1111);
        expect_grant(3, 4'b1111);
        expect_grant(0, 4'b1010);
        expect_grant(1, 4'b1010);
        expect_grant(3, 4'b1010);
        expect_grant(1, 4'b0000);
        drain();
        @(negedge clk);
        chk("fair_count", 32'(op_count), 32'd8);

        // backpressure
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        op_a[2]    = 8'h90;
        op_b[2]    = 8'h85;
        req_valid  = 4'b0100;
        expect_grant(2, '0);
        chk("bp_exec_valid", 32'(resp_valid), 32'd0);
        cnt0 = op_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", 32'({resp_sum, resp_carry, resp_id}), 32'({8'h15, 1'b1, 2'd2}));
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_after_valid", 32'(resp_valid), 32'd0);
        chk("bp_after_count", 32'(op_count), 32'(cnt0 + 16'd1));

        // reset while in EXEC
        @(posedge clk);
        #1;
        op_a[3]   = 8'h11;
        op_b[3]   = 8'h22;
        req_valid = 4'b1000;
        expect_grant(3, '0);
        reset_now();
        no_resp(6, 16'd0);

        // reset while in RESP
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        op_a[0]    = 8'h05;
        op_b[0]    = 8'h06;
        req_valid  = 4'b0001;
        expect_grant(0, '0);
        @(negedge clk);
        chk("resp_state_valid", 32'(resp_valid), 32'd1);
        reset_now();
        resp_ready = 1'b1;
        no_resp(6, 16'd0);

        // counter wrap
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        single(2, 8'hAB, 8'h55);
        @(negedge clk);
        chk("wrap_count", 32'(op_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
